// File: rtl/jpeg_quant_stream.sv
// Streaming JPEG quantizer: coefficient * reciprocal(step) with round-half-up and
// saturation, three-stage pipeline with valid/ready backpressure.
module jpeg_quant_stream #(
  parameter int IN_W    = 11,
  parameter int OUT_W   = 11,
  parameter int RECIP_W = 16,
  parameter int FRAC    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_coef,
  input  logic [1:0]         in_chan,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_coef,
  output logic               out_last,
  output logic [1:0]         out_chan,
  input  logic               tbl_we,
  input  logic               tbl_sel,
  input  logic [5:0]         tbl_addr,
  input  logic [RECIP_W-1:0] tbl_data
);

  localparam int PW   = IN_W + RECIP_W + 1;
  localparam int RW   = PW + 1;
  localparam int HALF = 1 << (FRAC - 1);
  localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(1 << (OUT_W - 1)));

  // Standard JPEG quantization steps, raster order.
  localparam int LUMA_Q [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };
  localparam int CHROMA_Q [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99
  };

  function automatic logic [RECIP_W-1:0] recip_of(input int q);
    return RECIP_W'((1 << FRAC) / q);
  endfunction

  logic [RECIP_W-1:0] luma_q   [64];
  logic [RECIP_W-1:0] luma_d   [64];
  logic [RECIP_W-1:0] chroma_q [64];
  logic [RECIP_W-1:0] chroma_d [64];

  logic [5:0]  idx_q, idx_d;
  logic [1:0]  chan_lat_q, chan_lat_d;

  logic                     v1_q, v1_d;
  logic signed [IN_W-1:0]   coef1_q, coef1_d;
  logic [RECIP_W-1:0]       recip1_q, recip1_d;
  logic                     last1_q, last1_d;
  logic [1:0]               chan1_q, chan1_d;

  logic                     v2_q, v2_d;
  logic signed [PW-1:0]     prod2_q, prod2_d;
  logic                     last2_q, last2_d;
  logic [1:0]               chan2_q, chan2_d;

  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_coef_q, out_coef_d;
  logic                     out_last_q, out_last_d;
  logic [1:0]               out_chan_q, out_chan_d;

  logic                     advance;
  logic                     accept;
  logic [1:0]               cur_chan;
  logic [RECIP_W-1:0]       lookup;
  logic signed [RW-1:0]     rsum;
  logic signed [RW-1:0]     rq;
  logic [OUT_W-1:0]         sat;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

  // Table reads see the pre-write contents; the write lands at the same edge.
  always_comb begin
    luma_d   = luma_q;
    chroma_d = chroma_q;
    if (tbl_we) begin
      if (tbl_sel) chroma_d[tbl_addr] = tbl_data;
      else         luma_d[tbl_addr]   = tbl_data;
    end
  end

  always_comb begin
    cur_chan = (idx_q == 6'd0) ? in_chan : chan_lat_q;
    lookup   = (cur_chan == 2'd1 || cur_chan == 2'd2) ? chroma_q[idx_q] : luma_q[idx_q];
    rsum     = RW'(prod2_q) + RW'(HALF);
    rq       = rsum >>> FRAC;
    if (rq > SAT_MAX)      sat = OUT_W'(SAT_MAX);
    else if (rq < SAT_MIN) sat = OUT_W'(SAT_MIN);
    else                   sat = OUT_W'(rq);
  end

  always_comb begin
    idx_d       = idx_q;
    chan_lat_d  = chan_lat_q;
    v1_d        = v1_q;
    coef1_d     = coef1_q;
    recip1_d    = recip1_q;
    last1_d     = last1_q;
    chan1_d     = chan1_q;
    v2_d        = v2_q;
    prod2_d     = prod2_q;
    last2_d     = last2_q;
    chan2_d     = chan2_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;

    if (accept) begin
      idx_d = idx_q + 6'd1;
      if (idx_q == 6'd0) chan_lat_d = in_chan;
    end

    // Whole pipeline, bubbles included, moves only on advance.
    if (advance) begin
      v1_d = accept;
      if (accept) begin
        coef1_d  = in_coef;
        recip1_d = lookup;
        last1_d  = (idx_q == 6'd63);
        chan1_d  = cur_chan;
      end

      v2_d = v1_q;
      if (v1_q) begin
        prod2_d = PW'(coef1_q) * PW'($signed({1'b0, recip1_q}));
        last2_d = last1_q;
        chan2_d = chan1_q;
      end

      out_valid_d = v2_q;
      if (v2_q) begin
        out_coef_d = sat;
        out_last_d = last2_q;
        out_chan_d = chan2_q;
      end else begin
        out_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 64; i++) begin
        luma_q[i]   <= recip_of(LUMA_Q[i]);
        chroma_q[i] <= recip_of(CHROMA_Q[i]);
      end
      idx_q       <= '0;
      chan_lat_q  <= '0;
      v1_q        <= 1'b0;
      coef1_q     <= '0;
      recip1_q    <= '0;
      last1_q     <= 1'b0;
      chan1_q     <= '0;
      v2_q        <= 1'b0;
      prod2_q     <= '0;
      last2_q     <= 1'b0;
      chan2_q     <= '0;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      luma_q      <= luma_d;
      chroma_q    <= chroma_d;
      idx_q       <= idx_d;
      chan_lat_q  <= chan_lat_d;
      v1_q        <= v1_d;
      coef1_q     <= coef1_d;
      recip1_q    <= recip1_d;
      last1_q     <= last1_d;
      chan1_q     <= chan1_d;
      v2_q        <= v2_d;
      prod2_q     <= prod2_d;
      last2_q     <= last2_d;
      chan2_q     <= chan2_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
    end
  end

endmodule
